// File: rtl/instr_pkg.sv
// Shared MIPS field widths, format codes and packing helpers for the
// instruction packer and anything that needs to build instruction words.
package instr_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNC_W  = 6;
   localparam int unsigned IMM16_W = 16;
   localparam int unsigned IMM26_W = 26;

   localparam logic [1:0] FMT_R   = 2'b00;
   localparam logic [1:0] FMT_I   = 2'b01;
   localparam logic [1:0] FMT_J   = 2'b10;
   localparam logic [1:0] FMT_BAD = 2'b11;

   function automatic logic [31:0] pack_r(
      input logic [OP_W-1:0]   op,
      input logic [REG_W-1:0]  rs,
      input logic [REG_W-1:0]  rt,
      input logic [REG_W-1:0]  rd,
      input logic [REG_W-1:0]  sh,
      input logic [FUNC_W-1:0] fn
   );
      return {op, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] pack_i(
      input logic [OP_W-1:0]    op,
      input logic [REG_W-1:0]   rs,
      input logic [REG_W-1:0]   rt,
      input logic [IMM16_W-1:0] imm
   );
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] pack_j(
      input logic [OP_W-1:0]    op,
      input logic [IMM26_W-1:0] tgt
   );
      return {op, tgt};
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered synchronous FIFO with occupancy count and synchronous clear.
// Read data is taken from storage only, so there is no write-to-read bypass.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign w_wr  = wr_en && !full && !clear;
   assign w_rd  = rd_en && !empty && !clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= wr_data;
   end

   // Storage contents are undefined until written, so hide them while empty.
   assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_packer.sv
// Packs MIPS R/I/J fields into 32-bit instruction words, buffers them and
// drains them tagged with a running byte address.
module instr_packer
   import instr_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [1:0]              fmt,
   input  logic [5:0]              opCode,
   input  logic [4:0]              rs_25_21,
   input  logic [4:0]              rt_20_16,
   input  logic [4:0]              rd_15_11,
   input  logic [4:0]              shamt,
   input  logic [5:0]              func,
   input  logic [15:0]             imm16,
   input  logic [25:0]             imm26,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_instr,
   output logic [31:0]             out_addr,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    err
);

   logic [31:0] w_packed;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic [31:0] r_addr;
   logic        r_err;

   always_comb begin
      w_packed = '0;
      case (fmt)
         FMT_R:   w_packed = pack_r(opCode, rs_25_21, rt_20_16, rd_15_11, shamt, func);
         FMT_I:   w_packed = pack_i(opCode, rs_25_21, rt_20_16, imm16);
         FMT_J:   w_packed = pack_j(opCode, imm26);
         default: w_packed = '0;
      endcase
   end

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_push    = w_accept && (fmt != FMT_BAD);
   assign w_pop     = out_valid && out_ready && !flush;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .wr_en   (w_push),
      .wr_data (w_packed),
      .rd_en   (w_pop),
      .rd_data (out_instr),
      .full    (w_full),
      .empty   (w_empty),
      .count   (count)
   );

   // An illegal-format handshake still completes; it only latches err.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr <= BASE_ADDR;
         r_err  <= 1'b0;
      end else if (flush) begin
         r_addr <= BASE_ADDR;
         r_err  <= 1'b0;
      end else begin
         if (w_pop) r_addr <= r_addr + 32'd4;
         if (w_accept && (fmt == FMT_BAD)) r_err <= 1'b1;
      end
   end

   assign out_addr = r_addr;
   assign err      = r_err;

endmodule

// File: tb/tb_instr_packer.sv
// Directed self-checking bench for instr_packer; a second instance with a
// high base address exercises address wrap.
module tb_instr_packer;
   import instr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [1:0]  fmt = 2'b00;
   logic [5:0]  opCode = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0, sh = '0;
   logic [5:0]  fn = '0;
   logic [15:0] imm16 = '0;
   logic [25:0] imm26 = '0;
   logic        in_ready, out_valid, err;
   logic [31:0] out_instr, out_addr;
   logic [2:0]  count;

   logic        w_in_valid = 1'b0;
   logic        w_out_ready = 1'b0;
   logic        w_in_ready, w_out_valid, w_err;
   logic [31:0] w_out_instr, w_out_addr;
   logic [2:0]  w_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_packer #(.DEPTH(4), .BASE_ADDR(32'h0000_3000)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opCode(opCode), .rs_25_21(rs), .rt_20_16(rt), .rd_15_11(rd),
      .shamt(sh), .func(fn), .imm16(imm16), .imm26(imm26), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr), .count(count), .err(err)
   );

   instr_packer #(.DEPTH(4), .BASE_ADDR(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .fmt(fmt), .opCode(opCode), .rs_25_21(rs), .rt_20_16(rt), .rd_15_11(rd),
      .shamt(sh), .func(fn), .imm16(imm16), .imm26(imm26), .out_valid(w_out_valid),
      .out_ready(w_out_ready), .out_instr(w_out_instr), .out_addr(w_out_addr), .count(w_count),
      .err(w_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_r(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                        input logic [5:0] f);
      fmt = FMT_R; opCode = 6'h00; rs = a; rt = b; rd = c; sh = 5'd0; fn = f;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b ready=%b count=%0d err=%b, required 0 1 0 0",
                  out_valid, in_ready, count, err);
      end
      checks++;
      if (out_addr !== 32'h0000_3000 || out_instr !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h instr=%h, required 00003000 00000000", out_addr, out_instr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_push_r();
      set_r(5'd8, 5'd9, 5'd10, 6'h21);
      in_valid = 1'b1;
      #3;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL no_bypass: out_valid=%b, required 0", out_valid);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0109_5021 || out_addr !== 32'h0000_3000) begin
         errors++;
         $display("FAIL push_r: valid=%b instr=%h addr=%h, required 1 01095021 00003000",
                  out_valid, out_instr, out_addr);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_addr !== 32'h0000_3004) begin
         errors++;
         $display("FAIL pop_r: valid=%b addr=%h, required 0 00003004", out_valid, out_addr);
      end
      do_flush();
      checks++;
      if (out_addr !== 32'h0000_3000) begin
         errors++;
         $display("FAIL flush_addr: addr=%h, required 00003000", out_addr);
      end
   endtask

   task automatic test_i_then_j();
      out_ready = 1'b1;
      fmt = FMT_I; opCode = 6'h0D; rs = 5'd0; rt = 5'd8; imm16 = 16'h1234;
      in_valid = 1'b1;
      step();
      checks++;
      if (out_instr !== 32'h3408_1234 || out_addr !== 32'h0000_3000 || count !== 3'd1) begin
         errors++;
         $display("FAIL push_i: instr=%h addr=%h count=%0d, required 34081234 00003000 1",
                  out_instr, out_addr, count);
      end
      fmt = FMT_J; opCode = 6'h02; imm26 = 26'h000_0C00;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_instr !== 32'h0800_0C00 || out_addr !== 32'h0000_3004 || count !== 3'd1) begin
         errors++;
         $display("FAIL push_j: instr=%h addr=%h count=%0d, required 08000c00 00003004 1",
                  out_instr, out_addr, count);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_addr !== 32'h0000_3008) begin
         errors++;
         $display("FAIL drain_ij: valid=%b addr=%h, required 0 00003008", out_valid, out_addr);
      end
      do_flush();
   endtask

   task automatic test_full();
      logic [31:0] exp_w [5];
      logic        acc;
      for (int k = 0; k < 5; k++)
         exp_w[k] = pack_r(6'h00, 5'(k + 1), 5'(k + 2), 5'(k + 3), 5'd0, 6'h20);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set_r(5'(k + 1), 5'(k + 2), 5'(k + 3), 6'h20);
         in_valid = 1'b1;
         step();
      end
      checks++;
      if (in_ready !== 1'b0 || count !== 3'd4) begin
         errors++;
         $display("FAIL full: in_ready=%b count=%0d, required 0 4", in_ready, count);
      end
      set_r(5'd5, 5'd6, 5'd7, 6'h20);
      step();
      checks++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL held: count=%0d in_ready=%b, required 4 0", count, in_ready);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_pop_ready: in_ready=%b, required 0", in_ready);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_instr !== exp_w[k] || out_addr !== 32'h3000 + 32'(4 * k)) begin
            errors++;
            $display("FAIL drain[%0d]: valid=%b instr=%h addr=%h, required 1 %h %h", k,
                     out_valid, out_instr, out_addr, exp_w[k], 32'h3000 + 32'(4 * k));
         end
         acc = in_valid && in_ready;
         step();
         if (acc) in_valid = 1'b0;
      end
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || in_valid !== 1'b0) begin
         errors++;
         $display("FAIL drained: valid=%b count=%0d pending=%b, required 0 0 0",
                  out_valid, count, in_valid);
      end
      do_flush();
   endtask

   task automatic test_illegal();
      fmt = FMT_BAD;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal: count=%0d valid=%b err=%b, required 0 0 1", count, out_valid, err);
      end
      set_r(5'd1, 5'd2, 5'd3, 6'h22);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      checks++;
      if (count !== 3'd1 || err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: count=%0d err=%b, required 1 1", count, err);
      end
      fmt = FMT_BAD;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (count !== 3'd0 || err !== 1'b1 || out_addr !== 32'h0000_3004) begin
         errors++;
         $display("FAIL illegal_pop: count=%0d err=%b addr=%h, required 0 1 00003004",
                  count, err, out_addr);
      end
      set_r(5'd4, 5'd5, 5'd6, 6'h20);
      in_valid = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (count !== 3'd0 || err !== 1'b0 || out_addr !== 32'h0000_3000 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush: count=%0d err=%b addr=%h valid=%b, required 0 0 00003000 0",
                  count, err, out_addr, out_valid);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 2; k++) begin
         set_r(5'(k), 5'd1, 5'd2, 6'h24);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (count !== 3'd1 || out_addr !== 32'h0000_3004) begin
         errors++;
         $display("FAIL pre_reset: count=%0d addr=%h, required 1 00003004", count, out_addr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || out_addr !== 32'h0000_3000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: valid=%b count=%0d addr=%h ready=%b, required 0 0 00003000 1",
                  out_valid, count, out_addr, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      fmt = FMT_I; opCode = 6'h23; rs = 5'd29; rt = 5'd31; imm16 = 16'hFFF0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_instr !== 32'h8FBF_FFF0 || out_addr !== 32'h0000_3000) begin
         errors++;
         $display("FAIL post_reset: instr=%h addr=%h, required 8fbffff0 00003000", out_instr, out_addr);
      end
   endtask

   task automatic test_wrap();
      fmt = FMT_J; opCode = 6'h03; imm26 = 26'h3FF_FFFF;
      w_in_valid = 1'b1;
      step();
      fmt = FMT_J; opCode = 6'h02; imm26 = 26'h000_0001;
      step();
      w_in_valid = 1'b0;
      w_out_ready = 1'b1;
      checks++;
      if (w_out_instr !== 32'h0FFF_FFFF || w_out_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap0: instr=%h addr=%h, required 0fffffff fffffffc", w_out_instr, w_out_addr);
      end
      step();
      checks++;
      if (w_out_instr !== 32'h0800_0001 || w_out_addr !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap1: instr=%h addr=%h, required 08000001 00000000", w_out_instr, w_out_addr);
      end
      step();
      w_out_ready = 1'b0;
      checks++;
      if (w_out_valid !== 1'b0 || w_out_addr !== 32'h0000_0004 || w_err !== 1'b0) begin
         errors++;
         $display("FAIL wrap_end: valid=%b addr=%h err=%b, required 0 00000004 0",
                  w_out_valid, w_out_addr, w_err);
      end
   endtask

   initial begin
      test_reset();
      test_push_r();
      test_i_then_j();
      test_full();
      test_illegal();
      test_async_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
